// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word and the fetch-stage state encoding.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    REDIR  = 2'd2,
    HALTED = 2'd3
  } fetch_state_t;

  localparam word_t WORD_BYTES = 32'd4;

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, requests instruction words, buffers a hit
// across a downstream stall and applies branch/jump redirects for the IF/ID latch.
module fetch_unit
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000
) (
  input  logic  CLK,
  input  logic  nRST,
  input  logic  ihit,
  input  word_t imemload,
  input  logic  stall,
  input  logic  redirect,
  input  word_t redirect_pc,
  input  logic  halt,
  output logic  imemREN,
  output word_t imemaddr,
  output word_t instr_o,
  output word_t npc_o,
  output word_t curr_pc_o,
  output logic  en_o,
  output logic  flush_o
);

  fetch_state_t r_state;
  word_t        r_pc;
  word_t        r_hold_instr;
  word_t        r_pend_pc;

  fetch_state_t w_state_nxt;
  word_t        w_pc_nxt;
  word_t        w_hold_nxt;
  word_t        w_pend_nxt;
  word_t        w_pc_plus4;
  logic         w_ren;
  logic         w_en;
  word_t        w_instr;

  assign w_pc_plus4 = r_pc + WORD_BYTES;
  assign curr_pc_o  = r_pc;
  assign npc_o      = w_pc_plus4;

  // Next-state and raw (pre-reset-gating) output decode; priority halt > redirect > stall.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_hold_nxt  = r_hold_instr;
    w_pend_nxt  = r_pend_pc;
    w_ren       = 1'b0;
    w_en        = 1'b0;
    w_instr     = 32'd0;
    case (r_state)
      FETCH: begin
        w_ren   = 1'b1;
        w_instr = imemload;
        if (halt) begin
          w_state_nxt = HALTED;
        end else if (redirect) begin
          if (ihit) begin
            w_pc_nxt = redirect_pc;
          end else begin
            // Miss still outstanding at the old address; remember the target.
            w_pend_nxt  = redirect_pc;
            w_state_nxt = REDIR;
          end
        end else if (ihit) begin
          if (stall) begin
            w_hold_nxt  = imemload;
            w_state_nxt = HOLD;
          end else begin
            w_en     = 1'b1;
            w_pc_nxt = w_pc_plus4;
          end
        end else begin
          w_state_nxt = FETCH;
        end
      end
      HOLD: begin
        w_instr = r_hold_instr;
        if (halt) begin
          w_state_nxt = HALTED;
        end else if (redirect) begin
          w_pc_nxt    = redirect_pc;
          w_state_nxt = FETCH;
        end else if (!stall) begin
          w_en        = 1'b1;
          w_pc_nxt    = w_pc_plus4;
          w_state_nxt = FETCH;
        end else begin
          w_state_nxt = HOLD;
        end
      end
      REDIR: begin
        w_ren = 1'b1;
        if (halt) begin
          w_state_nxt = HALTED;
        end else if (redirect) begin
          if (ihit) begin
            w_pc_nxt    = redirect_pc;
            w_state_nxt = FETCH;
          end else begin
            w_pend_nxt = redirect_pc;
          end
        end else if (ihit) begin
          w_pc_nxt    = r_pend_pc;
          w_state_nxt = FETCH;
        end else begin
          w_state_nxt = REDIR;
        end
      end
      HALTED: begin
        w_state_nxt = HALTED;
      end
      default: begin
        w_state_nxt = FETCH;
      end
    endcase
  end

  // Output drive, forced quiet while reset is held.
  always_comb begin
    if (!nRST) begin
      imemREN  = 1'b0;
      imemaddr = PC_INIT;
      instr_o  = 32'd0;
      en_o     = 1'b0;
      flush_o  = 1'b0;
    end else begin
      imemREN  = w_ren;
      imemaddr = r_pc;
      instr_o  = w_instr;
      en_o     = w_en;
      flush_o  = redirect;
    end
  end

  // State, PC and buffer registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state      <= FETCH;
      r_pc         <= PC_INIT;
      r_hold_instr <= 32'd0;
      r_pend_pc    <= 32'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_hold_instr <= w_hold_nxt;
      r_pend_pc    <= w_pend_nxt;
    end
  end

endmodule
